fetch_stage: RTL and testbench
==============================

FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 SHALL have parameters: WIDTH, default 36, PC and PC+1 width; INSTRUCTIONWIDTH, default 24, instruction width; OPCODEWIDTH, default 4, opcode field width (instruction MSBs); HALTOPCODE, default 4'hF, opcode that stops fetch.
REQ-002 SHALL have one clock; reset is asynchronous and active-low; ports named clock and reset.
REQ-003 SHALL have the following ports (name  direction  width  meaning):
- clock  in  1  rising-edge clock.
- reset  in  1  async active-low reset.
- stallF  in  1  hold PC.
- stallD  in  1  hold F/D register.
- flushD  in  1  clear F/D register to bubble.
- PCSelectorF  in  1  redirect PC to branchTargetF.
- branchTargetF  in  WIDTH  redirect address.
- instructionF  in  INSTRUCTIONWIDTH  instruction-memory data for pcF (combinational read).
- pcF  out  WIDTH  instruction-memory address.
- PCPlus1F  out  WIDTH  pcF+1, combinational.
- InstructionD  out  INSTRUCTIONWIDTH  registered instruction to decode.
- PCPlus1D  out  WIDTH  registered PC+1 to decode.
- validD  out  1  InstructionD is a real instruction.
- haltedF  out  1  fetch halted (sticky).

Function
REQ-004 SHALL compute PCPlus1F = pcF + 1 modulo 2^WIDTH; all-ones wraps to 0.
REQ-005 SHALL update pcF each rising edge with priority: haltedF=1 -> hold; else PCSelectorF=1 -> branchTargetF; else stallF=1 -> hold; else PCPlus1F.
REQ-006 SHALL give PCSelectorF priority over stallF (redirect is never lost to a stall).
REQ-007 SHALL update the F/D register each edge with priority: flushD=1 -> InstructionD=0, PCPlus1D=0, validD=0; else stallD=1 -> hold all three; else capture instructionF, PCPlus1F, validD = ~haltedF.
REQ-008 SHALL give flushD priority over stallD.
REQ-009 SHALL set haltedF on the edge where instructionF[INSTRUCTIONWIDTH-1 -: OPCODEWIDTH] == HALTOPCODE, PCSelectorF=0, stallF=0 and haltedF=0.
REQ-010 SHALL NOT set haltedF when a halt opcode coincides with PCSelectorF=1 (wrong-path halt is discarded).
REQ-011 SHALL capture the halt instruction itself with validD=1; every later non-stalled, non-flushed capture SHALL have validD=0.
REQ-012 SHALL clear haltedF only by reset.
REQ-013 SHALL give all outputs a latency of one edge from the inputs that cause them, except PCPlus1F, which is combinational.

Reset
REQ-014 SHALL asynchronously force, while reset=0: pcF=0, InstructionD=0, PCPlus1D=0, validD=0, haltedF=0 (and counters=0 when present).
REQ-015 SHALL fetch address 0 on the first rising edge after reset deasserts, with no partial state kept from any in-flight operation.

Configuration
REQ-016 SHALL, when FETCH_PERF_COUNTERS_EN is defined, add outputs fetchCount[31:0] and stallCount[31:0].
- fetchCount increments on each capture per REQ-007 with validD becoming 1.
- stallCount increments each edge with stallF=1 and haltedF=0.
- Both saturate at 32'hFFFF_FFFF.
REQ-017 SHALL, when FETCH_PERF_COUNTERS_EN is undefined, contain neither counter port nor counter logic; all other behaviour is identical.

Structure
REQ-018 SHALL place WIDTH, INSTRUCTIONWIDTH and OPCODEWIDTH defaults, HALTOPCODE, and the NOP instruction constant (all zeros) in shared package cpu_pkg.
REQ-019 SHALL implement the PC update as sub-module pc_register (async active-low reset, hold/load/increment); the F/D register SHALL be inline.

Verification
REQ-020 SHALL cover sequential fetch: reset, 4 idle cycles -> pcF 0,1,2,3,4; PCPlus1D 1,2,3,4; validD=1 from the first capture.
REQ-021 SHALL cover redirect vs stall: pcF=5, PCSelectorF=1, stallF=1, branchTargetF=36'h20 -> next pcF=36'h20.
REQ-022 SHALL cover flush vs stall: flushD=1 and stallD=1 together -> InstructionD=0, PCPlus1D=0, validD=0 next edge.
REQ-023 SHALL cover halt: instructionF=24'hF00000 at pcF=7 -> haltedF=1, pcF holds 7, halt captured with validD=1, subsequent validD=0; same instruction with PCSelectorF=1 -> no halt.
REQ-024 SHALL cover wrap: pcF=36'hF_FFFF_FFFF -> PCPlus1F=0, next pcF=0.
REQ-025 SHALL cover reset mid-operation: reset=0 asserted between edges while stallD=1 and haltedF=1 -> all outputs 0 immediately; fetch restarts at 0. With FETCH_PERF_COUNTERS_EN, 3 stall cycles -> stallCount=3.

Source files
------------

// File: rtl/cpu_pkg.sv
// cpu_pkg -- shared CPU constants used by the fetch stage and its PC register.
//   WIDTH_DEF        : default PC width
//   INSTR_WIDTH_DEF  : default instruction width
//   OPCODE_WIDTH_DEF : default opcode field width (instruction MSBs)
//   HALT_OPCODE      : opcode that stops fetch
//   NOP_INSTR        : bubble instruction loaded by a flush (all zeros)
package cpu_pkg;
    localparam int WIDTH_DEF        = 36;
    localparam int INSTR_WIDTH_DEF  = 24;
    localparam int OPCODE_WIDTH_DEF = 4;

    localparam logic [OPCODE_WIDTH_DEF-1:0] HALT_OPCODE = 4'hF;
    localparam logic [INSTR_WIDTH_DEF-1:0]  NOP_INSTR   = '0;
endpackage

// File: rtl/pc_register.sv
// pc_register -- program counter with load / hold / increment.
// Ports:
//   i_clock, i_reset_n : clock, async active-low reset (PC -> 0)
//   i_load, i_target   : load i_target (highest priority)
//   i_hold             : keep current PC
//   o_pc, o_pc_plus1   : current PC and PC+1 (combinational, wraps)
module pc_register
    import cpu_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic             i_clock,
    input  logic             i_reset_n,
    input  logic             i_load,
    input  logic             i_hold,
    input  logic [WIDTH-1:0] i_target,
    output logic [WIDTH-1:0] o_pc,
    output logic [WIDTH-1:0] o_pc_plus1
);
    logic [WIDTH-1:0] r_pc;

    assign o_pc       = r_pc;
    assign o_pc_plus1 = r_pc + WIDTH'(1);

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n)   r_pc <= '0;
        else if (i_load)  r_pc <= i_target;
        else if (!i_hold) r_pc <= o_pc_plus1;
    end
endmodule

// File: rtl/fetch_stage.sv
// fetch_stage -- instruction fetch with F/D pipeline register and sticky halt.
// Ports:
//   clock, reset                : clock, async active-low reset
//   stallF, PCSelectorF         : hold PC / redirect PC to branchTargetF
//   stallD, flushD              : hold / bubble the F/D register
//   instructionF                : imem data for pcF
//   pcF, PCPlus1F               : imem address and its successor
//   InstructionD, PCPlus1D, validD : F/D register contents
//   haltedF                     : fetch halted, cleared only by reset
// Optional: FETCH_PERF_COUNTERS_EN adds saturating fetchCount / stallCount.
module fetch_stage
    import cpu_pkg::*;
#(
    parameter int                      WIDTH            = WIDTH_DEF,
    parameter int                      INSTRUCTIONWIDTH = INSTR_WIDTH_DEF,
    parameter int                      OPCODEWIDTH      = OPCODE_WIDTH_DEF,
    parameter logic [OPCODEWIDTH-1:0]  HALTOPCODE       = HALT_OPCODE
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic                        stallF,
    input  logic                        stallD,
    input  logic                        flushD,
    input  logic                        PCSelectorF,
    input  logic [WIDTH-1:0]            branchTargetF,
    input  logic [INSTRUCTIONWIDTH-1:0] instructionF,
    output logic [WIDTH-1:0]            pcF,
    output logic [WIDTH-1:0]            PCPlus1F,
    output logic [INSTRUCTIONWIDTH-1:0] InstructionD,
    output logic [WIDTH-1:0]            PCPlus1D,
    output logic                        validD,
    output logic                        haltedF
`ifdef FETCH_PERF_COUNTERS_EN
    ,
    output logic [31:0]                 fetchCount,
    output logic [31:0]                 stallCount
`endif
);
    logic                        r_halted;
    logic [INSTRUCTIONWIDTH-1:0] r_instrD;
    logic [WIDTH-1:0]            r_pcPlus1D;
    logic                        r_validD;
    logic                        w_haltNow;
    logic                        w_pcLoad;
    logic                        w_pcHold;

    // A halt only counts on the correct path: a redirect this cycle means the
    // fetched word is wrong-path and is discarded.
    assign w_haltNow = (instructionF[INSTRUCTIONWIDTH-1 -: OPCODEWIDTH] == HALTOPCODE)
                       && !PCSelectorF && !stallF && !r_halted;

    // Redirect beats stall; once halted (or halting now) the PC freezes.
    assign w_pcLoad = !r_halted && PCSelectorF;
    assign w_pcHold = r_halted || w_haltNow || stallF;

    pc_register #(.WIDTH(WIDTH)) u_pc (
        .i_clock    (clock),
        .i_reset_n  (reset),
        .i_load     (w_pcLoad),
        .i_hold     (w_pcHold),
        .i_target   (branchTargetF),
        .o_pc       (pcF),
        .o_pc_plus1 (PCPlus1F)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_halted   <= 1'b0;
            r_instrD   <= '0;
            r_pcPlus1D <= '0;
            r_validD   <= 1'b0;
        end else begin
            if (w_haltNow) r_halted <= 1'b1;
            if (flushD) begin
                r_instrD   <= INSTRUCTIONWIDTH'(NOP_INSTR);
                r_pcPlus1D <= '0;
                r_validD   <= 1'b0;
            end else if (!stallD) begin
                r_instrD   <= instructionF;
                r_pcPlus1D <= PCPlus1F;
                // The halt word itself is still valid; only later ones are not.
                r_validD   <= !r_halted;
            end
        end
    end

    assign haltedF      = r_halted;
    assign InstructionD = r_instrD;
    assign PCPlus1D     = r_pcPlus1D;
    assign validD       = r_validD;

`ifdef FETCH_PERF_COUNTERS_EN
    logic [31:0] r_fetchCount;
    logic [31:0] r_stallCount;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_fetchCount <= '0;
            r_stallCount <= '0;
        end else begin
            if (!flushD && !stallD && !r_halted && (r_fetchCount != 32'hFFFF_FFFF))
                r_fetchCount <= r_fetchCount + 32'd1;
            if (stallF && !r_halted && (r_stallCount != 32'hFFFF_FFFF))
                r_stallCount <= r_stallCount + 32'd1;
        end
    end

    assign fetchCount = r_fetchCount;
    assign stallCount = r_stallCount;
`endif
endmodule

// File: tb/tb_fetch_stage.sv
module tb_fetch_stage;
    localparam int W  = 36;
    localparam int IW = 24;

    logic          clock = 1'b0;
    logic          reset;
    logic          stallF, stallD, flushD, PCSelectorF;
    logic [W-1:0]  branchTargetF;
    logic [IW-1:0] instructionF;
    logic [W-1:0]  pcF, PCPlus1F, PCPlus1D;
    logic [IW-1:0] InstructionD;
    logic          validD, haltedF;
`ifdef FETCH_PERF_COUNTERS_EN
    logic [31:0]   fetchCount, stallCount;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    fetch_stage dut (
        .clock         (clock),
        .reset         (reset),
        .stallF        (stallF),
        .stallD        (stallD),
        .flushD        (flushD),
        .PCSelectorF   (PCSelectorF),
        .branchTargetF (branchTargetF),
        .instructionF  (instructionF),
        .pcF           (pcF),
        .PCPlus1F      (PCPlus1F),
        .InstructionD  (InstructionD),
        .PCPlus1D      (PCPlus1D),
        .validD        (validD),
        .haltedF       (haltedF)
`ifdef FETCH_PERF_COUNTERS_EN
        ,
        .fetchCount    (fetchCount),
        .stallCount    (stallCount)
`endif
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic idle_inputs();
        stallF = 0; stallD = 0; flushD = 0; PCSelectorF = 0;
        branchTargetF = '0; instructionF = 24'h000001;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 1'b0;
        tick(); tick();
        reset = 1'b1;
    endtask

    typedef struct {
        logic          sF, sD, fD, sel;
        logic [W-1:0]  tgt;
        logic [IW-1:0] instr;
        logic [W-1:0]  e_pc;
        logic [IW-1:0] e_instrD;
        logic [W-1:0]  e_p1D;
        logic          e_valid, e_halted;
    } vec_t;

    vec_t vecs[13];

    // Behavioural model state
    logic [W-1:0]  m_pc, m_p1D;
    logic [IW-1:0] m_instrD;
    logic          m_valid, m_halted;
    int unsigned   m_fc, m_sc;

    task automatic model_reset();
        m_pc = '0; m_p1D = '0; m_instrD = '0; m_valid = 0; m_halted = 0;
        m_fc = 0; m_sc = 0;
    endtask

    task automatic model_step();
        bit halt_now;
        halt_now = (instructionF[23:20] == 4'hF) && !PCSelectorF && !stallF && !m_halted;
        if (!flushD && !stallD && !m_halted) m_fc++;
        if (stallF && !m_halted) m_sc++;
        if (flushD) begin
            m_instrD = '0; m_p1D = '0; m_valid = 0;
        end else if (!stallD) begin
            m_instrD = instructionF; m_p1D = m_pc + 36'd1; m_valid = !m_halted;
        end
        if (m_halted || halt_now) m_pc = m_pc;
        else if (PCSelectorF)     m_pc = branchTargetF;
        else if (!stallF)         m_pc = m_pc + 36'd1;
        if (halt_now) m_halted = 1;
    endtask

    task automatic check_model();
        chk("rand pcF", 64'(pcF), 64'(m_pc));
        chk("rand PCPlus1F", 64'(PCPlus1F), 64'(m_pc + 36'd1));
        chk("rand InstructionD", 64'(InstructionD), 64'(m_instrD));
        chk("rand PCPlus1D", 64'(PCPlus1D), 64'(m_p1D));
        chk("rand validD", 64'(validD), 64'(m_valid));
        chk("rand haltedF", 64'(haltedF), 64'(m_halted));
`ifdef FETCH_PERF_COUNTERS_EN
        chk("rand fetchCount", 64'(fetchCount), 64'(m_fc));
        chk("rand stallCount", 64'(stallCount), 64'(m_sc));
`endif
    endtask

    initial begin
        //        sF sD fD sel tgt      instr      e_pc   e_instrD   e_p1D  v  h
        vecs[0]  = '{0,0,0,0, 36'h0,  24'h000011, 36'h1,  24'h000011, 36'h1,  1,0};
        vecs[1]  = '{0,0,0,0, 36'h0,  24'h000022, 36'h2,  24'h000022, 36'h2,  1,0};
        vecs[2]  = '{0,0,0,0, 36'h0,  24'h000033, 36'h3,  24'h000033, 36'h3,  1,0};
        vecs[3]  = '{0,0,0,0, 36'h0,  24'h000044, 36'h4,  24'h000044, 36'h4,  1,0};
        vecs[4]  = '{0,0,0,0, 36'h0,  24'h000055, 36'h5,  24'h000055, 36'h5,  1,0};
        vecs[5]  = '{1,0,0,1, 36'h20, 24'h000066, 36'h20, 24'h000066, 36'h6,  1,0};
        vecs[6]  = '{1,0,0,0, 36'h0,  24'h000077, 36'h20, 24'h000077, 36'h21, 1,0};
        vecs[7]  = '{0,1,0,0, 36'h0,  24'h000088, 36'h21, 24'h000077, 36'h21, 1,0};
        vecs[8]  = '{0,1,1,0, 36'h0,  24'h000099, 36'h22, 24'h000000, 36'h0,  0,0};
        vecs[9]  = '{0,0,0,1, 36'h7,  24'hF00000, 36'h7,  24'hF00000, 36'h23, 1,0};
        vecs[10] = '{0,0,0,0, 36'h0,  24'hF00000, 36'h7,  24'hF00000, 36'h8,  1,1};
        vecs[11] = '{0,0,0,0, 36'h0,  24'h000123, 36'h7,  24'h000123, 36'h8,  0,1};
        vecs[12] = '{0,0,0,1, 36'h40, 24'h000ABC, 36'h7,  24'h000ABC, 36'h8,  0,1};

        idle_inputs();
        reset = 1'b0;
        #2;
        chk("reset pcF", 64'(pcF), 64'h0);
        chk("reset InstructionD", 64'(InstructionD), 64'h0);
        chk("reset PCPlus1D", 64'(PCPlus1D), 64'h0);
        chk("reset validD", 64'(validD), 64'h0);
        chk("reset haltedF", 64'(haltedF), 64'h0);
        do_reset();

        // Directed table from reset: sequential fetch, redirect vs stall,
        // flush vs stall, wrong-path halt, real halt at pc 7.
        for (int i = 0; i < 13; i++) begin
            stallF = vecs[i].sF; stallD = vecs[i].sD; flushD = vecs[i].fD;
            PCSelectorF = vecs[i].sel; branchTargetF = vecs[i].tgt;
            instructionF = vecs[i].instr;
            tick();
            chk($sformatf("vec%0d pcF", i), 64'(pcF), 64'(vecs[i].e_pc));
            chk($sformatf("vec%0d InstructionD", i), 64'(InstructionD), 64'(vecs[i].e_instrD));
            chk($sformatf("vec%0d PCPlus1D", i), 64'(PCPlus1D), 64'(vecs[i].e_p1D));
            chk($sformatf("vec%0d validD", i), 64'(validD), 64'(vecs[i].e_valid));
            chk($sformatf("vec%0d haltedF", i), 64'(haltedF), 64'(vecs[i].e_halted));
        end

        // Reset between edges while halted and stalled: outputs drop at once.
        stallD = 1'b1;
        #2 reset = 1'b0;
        #1;
        chk("midreset pcF", 64'(pcF), 64'h0);
        chk("midreset InstructionD", 64'(InstructionD), 64'h0);
        chk("midreset PCPlus1D", 64'(PCPlus1D), 64'h0);
        chk("midreset validD", 64'(validD), 64'h0);
        chk("midreset haltedF", 64'(haltedF), 64'h0);
        idle_inputs();
        #1 reset = 1'b1;
        instructionF = 24'h000042;
        tick();
        chk("restart pcF", 64'(pcF), 64'h1);
        chk("restart PCPlus1D", 64'(PCPlus1D), 64'h1);
        chk("restart InstructionD", 64'(InstructionD), 64'h000042);
        chk("restart validD", 64'(validD), 64'h1);

        // Wrap at all-ones.
        PCSelectorF = 1'b1; branchTargetF = 36'hF_FFFF_FFFF;
        tick();
        PCSelectorF = 1'b0;
        #1;
        chk("wrap PCPlus1F", 64'(PCPlus1F), 64'h0);
        tick();
        chk("wrap pcF", 64'(pcF), 64'h0);
        chk("wrap PCPlus1D", 64'(PCPlus1D), 64'h0);

`ifdef FETCH_PERF_COUNTERS_EN
        do_reset();
        stallF = 1'b1;
        repeat (3) tick();
        chk("stallCount 3", 64'(stallCount), 64'd3);
        chk("fetchCount 3", 64'(fetchCount), 64'd3);
        chk("stall pcF held", 64'(pcF), 64'h0);
        stallF = 1'b0;
`endif

        // Randomized run against the behavioural model, reset periodically so
        // halts don't freeze the rest of the run.
        do_reset();
        model_reset();
        for (int cyc = 0; cyc < 400; cyc++) begin
            if (cyc % 80 == 79) begin
                #2 reset = 1'b0;
                #1;
                model_reset();
                check_model();
                #1 reset = 1'b1;
            end
            stallF        = ($urandom_range(0, 3) == 0);
            stallD        = ($urandom_range(0, 4) == 0);
            flushD        = ($urandom_range(0, 6) == 0);
            PCSelectorF   = ($urandom_range(0, 6) == 0);
            branchTargetF = {4'($urandom()), 32'($urandom())};
            instructionF  = 24'($urandom());
            if (instructionF[23:20] == 4'hF && $urandom_range(0, 3) != 0)
                instructionF[23:20] = 4'h3;
            #1;
            chk("rand PCPlus1F comb", 64'(PCPlus1F), 64'(m_pc + 36'd1));
            model_step();
            tick();
            check_model();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, expected end before 200000");
        $fatal(1);
    end
endmodule
